// File: rtl/system_dispatcher.sv
// -----------------------------------------------------------------------------
// system_dispatcher
//
// Round-robin task dispatcher for periodic task channels. A system timer pulses
// trigger[i] once per period. The channel becomes pending and later receives a
// one-cycle start pulse when the arbiter grants it. The channel then counts as
// running until its done pulse. A channel that is triggered again while a period
// is already queued records a sticky overrun flag. Such an event also bumps a
// saturating overrun counter.
//
// Parameters
//   NUMBER        number of task channels (1..32)
//   COUNT_WIDTH   width of the saturating overrun event counter
//
// Ports
//   clock          single clock, all state changes on its rising edge
//   reset_n        asynchronous active-low reset
//   trigger        per-channel single-cycle period pulses
//   done           per-channel task-completion pulses
//   clear_overrun  synchronous clear of overrun flags and counter
//   start          registered one-hot-or-zero single-cycle start pulse
//   pending        registered: triggered but not yet started
//   running        registered: started and not yet done
//   overrun        registered sticky per-channel overrun flags
//   overrun_count  registered saturating count of cycles with any overrun
// -----------------------------------------------------------------------------
module system_dispatcher #(
    parameter int NUMBER      = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUMBER-1:0]      trigger,
    input  logic [NUMBER-1:0]      done,
    input  logic                   clear_overrun,
    output logic [NUMBER-1:0]      start,
    output logic [NUMBER-1:0]      pending,
    output logic [NUMBER-1:0]      running,
    output logic [NUMBER-1:0]      overrun,
    output logic [COUNT_WIDTH-1:0] overrun_count
);

    localparam int PTR_W = (NUMBER > 1) ? $clog2(NUMBER) : 1;

    logic [NUMBER-1:0]      start_reg,   start_next;
    logic [NUMBER-1:0]      pending_reg, pending_next;
    logic [NUMBER-1:0]      running_reg, running_next;
    logic [NUMBER-1:0]      overrun_reg, overrun_next;
    logic [COUNT_WIDTH-1:0] count_reg,   count_next;

    logic [NUMBER-1:0] eligible;
    logic [NUMBER-1:0] grant;
    logic [NUMBER-1:0] ovr_event;
    logic              any_event;

    // A channel may start only when a period is queued and no instance of it
    // is currently executing.
    assign eligible = pending_reg & ~running_reg;

    generate
        if (NUMBER == 1) begin : g_single
            // A single channel needs no pointer. Arbitration is just eligibility.
            assign grant = eligible;
        end else begin : g_rr
            logic [PTR_W-1:0]  ptr_reg, ptr_next;
            logic [PTR_W-1:0]  grant_idx;
            logic [NUMBER-1:0] ge_mask;
            logic [NUMBER-1:0] upper_elig;
            logic              any_grant;

            // Mask of channel indices at or above the round-robin pointer.
            for (genvar gi = 0; gi < NUMBER; gi++) begin : g_mask
                assign ge_mask[gi] = (PTR_W'(gi) >= ptr_reg);
            end

            // Search first from ptr upward. If nothing is eligible there, wrap
            // and take the lowest eligible index. The x & -x idiom keeps only
            // the lowest set bit, so the grant is one-hot.
            assign upper_elig = eligible & ge_mask;
            assign grant = (|upper_elig)
                         ? (upper_elig & (~upper_elig + NUMBER'(1)))
                         : (eligible   & (~eligible   + NUMBER'(1)));
            assign any_grant = |grant;

            always_comb begin
                grant_idx = '0;
                for (int k = 0; k < NUMBER; k++) begin
                    if (grant[k]) begin
                        grant_idx = PTR_W'(k);
                    end
                end
            end

            // The pointer moves one past the winner and stays put when idle.
            always_comb begin
                ptr_next = ptr_reg;
                if (any_grant) begin
                    if (grant_idx == PTR_W'(NUMBER - 1)) begin
                        ptr_next = '0;
                    end else begin
                        ptr_next = grant_idx + PTR_W'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    ptr_reg <= '0;
                end else begin
                    ptr_reg <= ptr_next;
                end
            end
        end
    endgenerate

    // Per-channel next-state logic.
    generate
        for (genvar gi = 0; gi < NUMBER; gi++) begin : g_chan
            // A re-trigger with a period already queued is lost, so it is an
            // overrun. The one exception is the edge where the queued period
            // is handed off by the grant.
            assign ovr_event[gi] = trigger[gi] & pending_reg[gi] & ~grant[gi];

            // On a grant, the queued period is consumed. A coincident trigger
            // immediately queues the next one.
            assign pending_next[gi] = grant[gi] ? trigger[gi]
                                                : (pending_reg[gi] | trigger[gi]);

            // A granted channel was not running, so done cannot collide with
            // the grant. done on an idle channel leaves it idle.
            assign running_next[gi] = grant[gi] | (running_reg[gi] & ~done[gi]);

            // A new event overrides a simultaneous clear.
            assign overrun_next[gi] = ovr_event[gi] | (overrun_reg[gi] & ~clear_overrun);

            assign start_next[gi] = grant[gi];
        end
    endgenerate

    assign any_event = |ovr_event;

    // The counter counts cycles that have at least one overrun, not individual
    // channel events. It saturates. A clear in the same cycle as an event
    // leaves the count at 1.
    always_comb begin
        count_next = clear_overrun ? '0 : count_reg;
        if (any_event) begin
            if (clear_overrun) begin
                count_next = COUNT_WIDTH'(1);
            end else if (count_reg != {COUNT_WIDTH{1'b1}}) begin
                count_next = count_reg + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_reg   <= '0;
            pending_reg <= '0;
            running_reg <= '0;
            overrun_reg <= '0;
            count_reg   <= '0;
        end else begin
            start_reg   <= start_next;
            pending_reg <= pending_next;
            running_reg <= running_next;
            overrun_reg <= overrun_next;
            count_reg   <= count_next;
        end
    end

    assign start         = start_reg;
    assign pending       = pending_reg;
    assign running       = running_reg;
    assign overrun       = overrun_reg;
    assign overrun_count = count_reg;

endmodule

// File: tb/tb_system_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_system_dispatcher
//
// Testbench for system_dispatcher with NUMBER=3 and COUNT_WIDTH=2. A
// behavioural model of the dispatcher rules runs alongside the DUT. Each test
// task drives one scenario and compares the DUT outputs against the model and
// against the fixed values of the worked examples.
// -----------------------------------------------------------------------------
module tb_system_dispatcher;

    localparam int N    = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset_n;
    logic [N-1:0]  trigger;
    logic [N-1:0]  done;
    logic          clear_overrun;
    logic [N-1:0]  start;
    logic [N-1:0]  pending;
    logic [N-1:0]  running;
    logic [N-1:0]  overrun;
    logic [CW-1:0] overrun_count;

    int compared   = 0;
    int mismatched = 0;

    system_dispatcher #(.NUMBER(N), .COUNT_WIDTH(CW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .trigger       (trigger),
        .done          (done),
        .clear_overrun (clear_overrun),
        .start         (start),
        .pending       (pending),
        .running       (running),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state.
    bit [N-1:0] m_start, m_pend, m_run, m_ovr;
    int         m_cnt;
    int         m_ptr;

    logic [4*N+CW-1:0] obs_vec;
    assign obs_vec = {start, pending, running, overrun, overrun_count};

    function automatic logic [4*N+CW-1:0] exp_vec();
        return {m_start, m_pend, m_run, m_ovr, CW'(m_cnt)};
    endfunction

    function automatic void model_reset();
        m_start = '0; m_pend = '0; m_run = '0; m_ovr = '0;
        m_cnt = 0; m_ptr = 0;
    endfunction

    // One clock edge of the dispatcher rules.
    function automatic void model_step(input bit [N-1:0] trg, input bit [N-1:0] dn,
                                       input bit clr);
        int g = -1;
        bit any_ev = 0;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (g < 0 && m_pend[i] && !m_run[i]) g = i;
        end
        m_start = '0;
        for (int i = 0; i < N; i++) begin
            bit ev = trg[i] && m_pend[i] && (i != g);
            if (ev) any_ev = 1;
            if (clr) m_ovr[i] = 0;
            if (ev)  m_ovr[i] = 1;
            if (i == g) begin
                m_start[i] = 1;
                m_pend[i]  = trg[i];
                m_run[i]   = 1;
            end else begin
                m_pend[i] = m_pend[i] | trg[i];
                if (dn[i]) m_run[i] = 0;
            end
        end
        if (clr) m_cnt = 0;
        if (any_ev) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (g >= 0) m_ptr = (g + 1) % N;
    endfunction

    // Applies one cycle of inputs and advances DUT and model by one edge.
    // Returns 1 ns after the edge with the inputs back at idle.
    task automatic step(input logic [N-1:0] trg, input logic [N-1:0] dn, input logic clr);
        trigger = trg; done = dn; clear_overrun = clr;
        @(posedge clock);
        model_step(trg, dn, clr);
        #1;
        trigger = '0; done = '0; clear_overrun = 1'b0;
        $display("[%0t] trig=%b done=%b clr=%b -> start=%b pend=%b run=%b ovr=%b cnt=%0d",
                 $time, trg, dn, clr, start, pending, running, overrun, overrun_count);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; trigger = '0; done = '0; clear_overrun = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        compared++;
        if (obs_vec !== '0) begin
            mismatched++;
            $display("FAIL reset_async: got %b want %b", obs_vec, {(4*N+CW){1'b0}});
        end
        // Triggers during reset must be discarded.
        trigger = 3'b111;
        @(posedge clock);
        #1;
        compared++;
        if (obs_vec !== '0) begin
            mismatched++;
            $display("FAIL reset_hold: got %b want %b", obs_vec, {(4*N+CW){1'b0}});
        end
        trigger = '0;
        reset_n = 1'b1;
        step('0, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || start !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_release: got %b want %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] trg_seq [6] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [N-1:0] dn_seq  [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(trg_seq[c], dn_seq[c], 1'b0);
            compared++;
            if (obs_vec !== exp_vec()) begin
                mismatched++;
                $display("FAIL basic_c%0d: got %b want %b", c + 1, obs_vec, exp_vec());
            end
            if (c == 0) begin
                compared++;
                if (pending !== 3'b001 || start !== 3'b000) begin
                    mismatched++;
                    $display("FAIL basic_pending: got pend=%b start=%b want 001 000", pending, start);
                end
            end
            if (c == 1) begin
                compared++;
                if (start !== 3'b001 || running !== 3'b001 || pending !== 3'b000) begin
                    mismatched++;
                    $display("FAIL basic_start: got start=%b run=%b pend=%b want 001 001 000",
                             start, running, pending);
                end
            end
            if (c == 2) begin
                compared++;
                if (start !== 3'b000 || running !== 3'b001) begin
                    mismatched++;
                    $display("FAIL basic_pulse: got start=%b run=%b want 000 001", start, running);
                end
            end
            if (c == 5) begin
                compared++;
                if (running !== 3'b000) begin
                    mismatched++;
                    $display("FAIL basic_done: got run=%b want 000", running);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want_start [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
        do_reset();
        step(3'b111, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || pending !== 3'b111) begin
            mismatched++;
            $display("FAIL rr_pending: got %b want %b", obs_vec, exp_vec());
        end
        for (int c = 0; c < 4; c++) begin
            step('0, '0, 1'b0);
            compared++;
            if (obs_vec !== exp_vec() || start !== want_start[c]) begin
                mismatched++;
                $display("FAIL rr_c%0d: got start=%b want %b (full %b vs %b)",
                         c + 2, start, want_start[c], obs_vec, exp_vec());
            end
        end
        // The pointer wrapped to 0, so channel 0 beats channel 1 next time.
        step('0, 3'b111, 1'b0);
        step(3'b011, '0, 1'b0);
        step('0, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || start !== 3'b001) begin
            mismatched++;
            $display("FAIL rr_ptr_wrap: got start=%b want 001", start);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        step(3'b001, '0, 1'b0);
        step('0, '0, 1'b0);
        step(3'b001, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || pending !== 3'b001 || overrun !== 3'b000
            || overrun_count !== 2'd0) begin
            mismatched++;
            $display("FAIL ovr_queue: got %b want %b", obs_vec, exp_vec());
        end
        step(3'b001, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || overrun !== 3'b001 || overrun_count !== 2'd1) begin
            mismatched++;
            $display("FAIL ovr_first: got ovr=%b cnt=%0d want 001 1", overrun, overrun_count);
        end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 4; c++) step(3'b001, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || overrun_count !== 2'd3) begin
            mismatched++;
            $display("FAIL sat_count: got cnt=%0d want 3", overrun_count);
        end
        step('0, '0, 1'b1);
        compared++;
        if (obs_vec !== exp_vec() || overrun_count !== 2'd0 || overrun !== 3'b000) begin
            mismatched++;
            $display("FAIL sat_clear: got ovr=%b cnt=%0d want 000 0", overrun, overrun_count);
        end
        step(3'b001, '0, 1'b1);
        compared++;
        if (obs_vec !== exp_vec() || overrun_count !== 2'd1 || overrun !== 3'b001) begin
            mismatched++;
            $display("FAIL sat_clear_event: got ovr=%b cnt=%0d want 001 1", overrun, overrun_count);
        end
    endtask

    task automatic test_grant_trigger();
        do_reset();
        step(3'b001, '0, 1'b0);
        step(3'b001, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || start !== 3'b001 || pending !== 3'b001
            || overrun !== 3'b000 || overrun_count !== 2'd0) begin
            mismatched++;
            $display("FAIL grant_trigger: got %b want %b", obs_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(3'b001, '0, 1'b0);
        step('0, '0, 1'b0);
        step(3'b110, '0, 1'b0);
        compared++;
        if (obs_vec !== exp_vec() || pending !== 3'b110 || running !== 3'b001) begin
            mismatched++;
            $display("FAIL mid_setup: got pend=%b run=%b want 110 001", pending, running);
        end
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        compared++;
        if (obs_vec !== '0) begin
            mismatched++;
            $display("FAIL mid_async: got %b want all zero", obs_vec);
        end
        #2 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step('0, '0, 1'b0);
            compared++;
            if (obs_vec !== exp_vec() || start !== 3'b000) begin
                mismatched++;
                $display("FAIL mid_idle_c%0d: got %b want %b", c, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] trg, dn;
        logic         clr;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                trg[i] = ($urandom_range(0, 3) == 0);
                dn[i]  = ($urandom_range(0, 2) == 0);
            end
            clr = ($urandom_range(0, 19) == 0);
            step(trg, dn, clr);
            compared++;
            if (obs_vec !== exp_vec()) begin
                mismatched++;
                $display("FAIL random_c%0d: got %b want %b", c, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_overrun();
        test_saturate();
        test_grant_trigger();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
